// File: rtl/apb_retention_regfile.sv
// APB register bank whose registers are mirrored into the always-on ref_clk_i
// domain. Every write is carried across by a 4-phase req/ack handshake. After
// HRESETn the selected registers are reloaded from their always-on copies.
//
// HCLK-side FSM
//   state      | meaning
//   ST_RESTORE | after HRESETn: wait for the synchronisers, reload masked regs
//   ST_IDLE    | serve reads and error responses, accept one valid write
//   ST_REQ     | req high, waiting for the synced ack to rise
//   ST_ACK     | req low, waiting for the synced ack to fall
//   ST_DONE    | one-cycle PREADY completing the stalled write
module apb_retention_regfile #(
    parameter int                     APB_ADDR_WIDTH = 12,
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     NUM_REGS       = 4,
    parameter int                     SYNC_STAGES    = 2,
    parameter logic [NUM_REGS-1:0]    RESTORE_MASK   = {NUM_REGS{1'b1}},
    parameter logic [31:0]            SIGNATURE      = 32'h00DA41DE
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    input  logic                           ref_clk_i,
    input  logic                           rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0]      PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    input  logic                           PWRITE,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] sys_reg_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] aon_reg_o,
    output logic [NUM_REGS-1:0]            aon_wr_pulse_o,
    output logic                           restore_done_o
);

    localparam int                     NUM_BYTES = DATA_WIDTH / 8;
    localparam int                     CNT_W     = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]       CNT_INIT  = CNT_W'(SYNC_STAGES);
    localparam logic [5:0]             LAST_IDX  = 6'(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0]  SIG_WORD  = DATA_WIDTH'(SIGNATURE);

    typedef enum logic [2:0] {
        ST_RESTORE,
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_DONE
    } state_e;

    // ---------------- HCLK domain state ----------------
    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sys_reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   sys_reg_d [NUM_REGS];
    logic [NUM_REGS-1:0]     hold_sel_q, hold_sel_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    req_q, req_d;
    logic                    restore_done_q, restore_done_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q, ack_sync_d;

    // ---------------- ref_clk_i domain state ----------------
    logic [SYNC_STAGES-1:0]  req_sync_q, req_sync_d;
    logic                    req_prev_q, req_prev_d;
    logic [DATA_WIDTH-1:0]   aon_reg_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   aon_reg_d [NUM_REGS];
    logic [NUM_REGS-1:0]     aon_pulse_q, aon_pulse_d;

    // ---------------- decode ----------------
    logic [5:0]              reg_idx;
    logic                    sig_hit;
    logic                    reg_hit;
    logic                    access;
    logic                    ack_synced;
    logic                    req_edge;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic [DATA_WIDTH-1:0]   merged;
    logic [NUM_REGS-1:0]     idx_onehot;
    logic                    unused_addr;

    assign reg_idx     = PADDR[7:2];
    assign sig_hit     = (reg_idx == 6'd0);
    assign reg_hit     = (reg_idx != 6'd0) && (reg_idx <= LAST_IDX);
    assign access      = PSEL && PENABLE;
    assign ack_synced  = ack_sync_q[SYNC_STAGES-1];
    assign req_edge    = req_sync_q[SYNC_STAGES-1] && !req_prev_q;
    assign unused_addr = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};

    // Byte-strobe expansion, selected register value and merged write word.
    always_comb begin
        byte_mask  = '0;
        rd_val     = '0;
        idx_onehot = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            byte_mask[b*8 +: 8] = {8{PSTRB[b]}};
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_idx == 6'(i + 1)) begin
                rd_val        = sys_reg_q[i];
                idx_onehot[i] = 1'b1;
            end
        end
        merged = (rd_val & ~byte_mask) | (PWDATA & byte_mask);
    end

    // Next-state logic and APB responses of the HCLK FSM.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sys_reg_d      = sys_reg_q;
        hold_sel_d     = hold_sel_q;
        hold_data_d    = hold_data_q;
        req_d          = req_q;
        restore_done_d = restore_done_q;
        PREADY         = 1'b0;
        PSLVERR        = 1'b0;
        unique case (state_q)
            ST_RESTORE: begin
                if (cnt_q == '0) begin
                    // The aon copies are quiet here: the ref-side synchroniser
                    // was held in reset with us, so no write can be in flight.
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (RESTORE_MASK[i]) begin
                            sys_reg_d[i] = aon_reg_q[i];
                        end
                    end
                    restore_done_d = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_IDLE: begin
                PREADY = 1'b1;
                if (access) begin
                    if (PWRITE) begin
                        if (reg_hit) begin
                            PREADY      = 1'b0;
                            hold_sel_d  = idx_onehot;
                            hold_data_d = merged;
                            req_d       = 1'b1;
                            state_d     = ST_REQ;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (idx_onehot[i]) begin
                                    sys_reg_d[i] = merged;
                                end
                            end
                        end else begin
                            PSLVERR = 1'b1;
                        end
                    end else if (!reg_hit && !sig_hit) begin
                        PSLVERR = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (ack_synced) begin
                    req_d   = 1'b0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!ack_synced) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                PREADY  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_RESTORE;
            end
        endcase
    end

    // Read data is driven only while a read can actually complete.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && (state_q == ST_IDLE)) begin
            if (sig_hit) begin
                PRDATA = SIG_WORD;
            end else if (reg_hit) begin
                PRDATA = rd_val;
            end
        end
    end

    // ack returns to HCLK through its own synchroniser.
    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], req_sync_q[SYNC_STAGES-1]};
    end

    // HCLK-domain registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= ST_RESTORE;
            cnt_q          <= CNT_INIT;
            hold_sel_q     <= '0;
            hold_data_q    <= '0;
            req_q          <= 1'b0;
            restore_done_q <= 1'b0;
            ack_sync_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                sys_reg_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_sel_q     <= hold_sel_d;
            hold_data_q    <= hold_data_d;
            req_q          <= req_d;
            restore_done_q <= restore_done_d;
            ack_sync_q     <= ack_sync_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                sys_reg_q[i] <= sys_reg_d[i];
            end
        end
    end

    // req synchroniser and edge detector on the always-on side.
    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_q};
        req_prev_d = req_sync_q[SYNC_STAGES-1];
    end

    // Synchroniser is cleared by HRESETn so an interrupted request can never
    // produce a late or duplicate edge.
    always_ff @(posedge ref_clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            req_sync_q <= '0;
            req_prev_q <= 1'b0;
        end else begin
            req_sync_q <= req_sync_d;
            req_prev_q <= req_prev_d;
        end
    end

    // Retained copy update: the hold registers are stable for the whole req
    // window, so a full word is captured on the synced rising edge.
    always_comb begin
        aon_reg_d   = aon_reg_q;
        aon_pulse_d = '0;
        if (req_edge) begin
            aon_pulse_d = hold_sel_q;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (hold_sel_q[i]) begin
                    aon_reg_d[i] = hold_data_q;
                end
            end
        end
    end

    // Always-on registers survive HRESETn; only rstn_i clears them.
    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            aon_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                aon_reg_q[i] <= '0;
            end
        end else begin
            aon_pulse_q <= aon_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                aon_reg_q[i] <= aon_reg_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign sys_reg_o[g*DATA_WIDTH +: DATA_WIDTH] = sys_reg_q[g];
        assign aon_reg_o[g*DATA_WIDTH +: DATA_WIDTH] = aon_reg_q[g];
    end

    assign aon_wr_pulse_o = aon_pulse_q;
    assign restore_done_o = restore_done_q;

endmodule

// File: tb/tb_apb_retention_regfile.sv
// Directed bench for apb_retention_regfile with a register-level model and a
// per-cycle compare of the HCLK and always-on register images.
module tb_apb_retention_regfile;

    localparam logic [3:0] MASK = 4'b1101;

    logic         HCLK = 1'b0;
    logic         ref_clk_i = 1'b0;
    logic         HRESETn = 1'b0;
    logic         rstn_i = 1'b0;
    logic [11:0]  PADDR = '0;
    logic [31:0]  PWDATA = '0;
    logic [3:0]   PSTRB = '0;
    logic         PWRITE = 1'b0;
    logic         PSEL = 1'b0;
    logic         PENABLE = 1'b0;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [127:0] sys_reg_o;
    logic [127:0] aon_reg_o;
    logic [3:0]   aon_wr_pulse_o;
    logic         restore_done_o;

    apb_retention_regfile #(
        .APB_ADDR_WIDTH(12),
        .DATA_WIDTH    (32),
        .NUM_REGS      (4),
        .SYNC_STAGES   (2),
        .RESTORE_MASK  (MASK),
        .SIGNATURE     (32'h00DA41DE)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .ref_clk_i     (ref_clk_i),
        .rstn_i        (rstn_i),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PSTRB         (PSTRB),
        .PWRITE        (PWRITE),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .sys_reg_o     (sys_reg_o),
        .aon_reg_o     (aon_reg_o),
        .aon_wr_pulse_o(aon_wr_pulse_o),
        .restore_done_o(restore_done_o)
    );

    always #5 HCLK = ~HCLK;
    always #7 ref_clk_i = ~ref_clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_sys [4];
    logic [31:0] m_aon [4];
    int          pulse_cnt [4];
    logic        chk_en = 1'b0;
    logic        hs_busy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [11:0] addr);
        int idx = int'(addr[7:2]);
        if (idx == 0) return 32'h00DA41DE;
        if (idx <= 4) return m_sys[idx-1];
        return 32'h0;
    endfunction

    // After HRESETn: masked registers come back from the aon copy, others are 0.
    task automatic restore_model();
        for (int i = 0; i < 4; i++) m_sys[i] = MASK[i] ? m_aon[i] : 32'h0;
    endtask

    // Pulse monitor: a one-ref-cycle pulse is seen by exactly one sample.
    always @(negedge ref_clk_i) begin
        for (int i = 0; i < 4; i++) if (aon_wr_pulse_o[i]) pulse_cnt[i]++;
    end

    // Per-cycle compare of both register images against the model.
    always @(negedge HCLK) begin
        if (chk_en && restore_done_o) begin
            chk("sys_reg_o", sys_reg_o, {m_sys[3], m_sys[2], m_sys[1], m_sys[0]});
            if (!hs_busy) chk("aon_reg_o", aon_reg_o, {m_aon[3], m_aon[2], m_aon[1], m_aon[0]});
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output int waits);
        int          idx = int'(addr[7:2]);
        logic        commit = wr && idx >= 1 && idx <= 4;
        logic [31:0] mrg = 32'h0;
        logic        rdy = 1'b0;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        waits = 0; err = 1'b0; rdata = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge HCLK);
            rdy = PREADY; err = PSLVERR; rdata = PRDATA;
            @(posedge HCLK); #1;
            if (i == 0 && commit) begin
                mrg = m_sys[idx-1];
                for (int b = 0; b < 4; b++) if (strb[b]) mrg[b*8 +: 8] = wdata[b*8 +: 8];
                m_sys[idx-1] = mrg;
                hs_busy = 1'b1;
            end
            if (rdy) break;
            waits++;
        end
        chk("xfer_completed", rdy, 1'b1);
        PSEL = 1'b0; PENABLE = 1'b0;
        if (commit) m_aon[idx-1] = mrg;
        hs_busy = 1'b0;
    endtask

    task automatic wait_restore(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge HCLK);
            if (restore_done_o) break;
        end
        chk(name, restore_done_o, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        int          cyc;
        int          p0 [4];
        logic [31:0] aon2;
        logic        got_new;

        for (int i = 0; i < 4; i++) begin
            m_sys[i] = '0; m_aon[i] = '0; pulse_cnt[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge HCLK);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_restore_done", restore_done_o, 1'b0);
        chk("rst_aon", aon_reg_o, 128'h0);
        chk("rst_pulse", aon_wr_pulse_o, 4'h0);
        rstn_i = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge HCLK);
            cyc++;
            if (restore_done_o) break;
        end
        chk("restore_cycles", cyc, 3);
        restore_model();
        chk_en = 1'b1;

        // 1: signature and empty register, plus read-range boundaries
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        chk("t1_sig", rd, 32'h00DA41DE);
        chk("t1_sig_err", er, 1'b0);
        chk("t1_sig_waits", w, 0);
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        chk("t1_reg0", rd, 32'h0);
        chk("t1_reg0_err", er, 1'b0);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
        chk("t1_last_reg_err", er, 1'b0);
        apb_xfer(1'b0, 12'h014, 32'h0, 4'h0, rd, er, w);
        chk("t1_invalid_rd", rd, 32'h0);
        chk("t1_invalid_err", er, 1'b1);

        // 2: full write through the handshake
        for (int i = 0; i < 4; i++) p0[i] = pulse_cnt[i];
        apb_xfer(1'b1, 12'h008, 32'hCAFEBABE, 4'hF, rd, er, w);
        chk("t2_err", er, 1'b0);
        chk("t2_waits_range", (w >= 4 && w <= 20), 1'b1);
        chk("t2_aon1", aon_reg_o[63:32], 32'hCAFEBABE);
        chk("t2_pulse1", pulse_cnt[1] - p0[1], 1);
        chk("t2_pulse_others", pulse_cnt[0] + pulse_cnt[2] + pulse_cnt[3]
                               - p0[0] - p0[2] - p0[3], 0);
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        chk("t2_readback", rd, 32'hCAFEBABE);

        // 3: single-byte strobe merge
        apb_xfer(1'b1, 12'h008, 32'h0000AB00, 4'b0010, rd, er, w);
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        chk("t3_readback", rd, 32'hCAFEABBE);
        chk("t3_model", rd, exp_read(12'h008));
        chk("t3_aon1", aon_reg_o[63:32], 32'hCAFEABBE);

        // Low address bits ignored; byte 0 and byte 3 strobes
        apb_xfer(1'b1, 12'h00F, 32'h12345678, 4'b1001, rd, er, w);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, rd, er, w);
        chk("t3b_readback", rd, 32'h12000078);

        // 4: writes to signature and beyond the last register
        for (int i = 0; i < 4; i++) p0[i] = pulse_cnt[i];
        apb_xfer(1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, rd, er, w);
        chk("t4_sig_wr_err", er, 1'b1);
        chk("t4_sig_wr_waits", w, 0);
        apb_xfer(1'b1, 12'h014, 32'hFFFFFFFF, 4'hF, rd, er, w);
        chk("t4_inv_wr_err", er, 1'b1);
        chk("t4_inv_wr_waits", w, 0);
        repeat (10) @(negedge HCLK);
        chk("t4_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]
                           - p0[0] - p0[1] - p0[2] - p0[3], 0);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, rd, er, w);
        chk("t4_sig_intact", rd, 32'h00DA41DE);

        // 5: selective restore after an HRESETn pulse
        apb_xfer(1'b1, 12'h004, 32'h00000011, 4'hF, rd, er, w);
        apb_xfer(1'b1, 12'h008, 32'h00000022, 4'hF, rd, er, w);
        @(negedge HCLK);
        chk_en = 1'b0;
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        chk("t5_rst_sys", sys_reg_o, 128'h0);
        chk("t5_rst_done", restore_done_o, 1'b0);
        chk("t5_rst_aon1", aon_reg_o[63:32], 32'h00000022);
        restore_model();
        HRESETn = 1'b1;
        chk_en = 1'b1;
        apb_xfer(1'b0, 12'h004, 32'h0, 4'h0, rd, er, w);
        chk("t5_read_stalled", (w >= 1), 1'b1);
        chk("t5_reg0", rd, 32'h00000011);
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, rd, er, w);
        chk("t5_reg1", rd, 32'h0);
        chk("t5_aon1_kept", aon_reg_o[63:32], 32'h00000022);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, rd, er, w);
        chk("t5_reg2", rd, 32'h12000078);

        // 6: HRESETn while the FSM sits in REQ
        for (int i = 0; i < 4; i++) p0[i] = pulse_cnt[i];
        chk_en = 1'b0;
        @(posedge HCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C;
        PWDATA = 32'hA5A5A5A5; PSTRB = 4'hF;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("t6_stalled", PREADY, 1'b0);
        HRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (12) @(posedge ref_clk_i);
        #3 HRESETn = 1'b1;
        wait_restore("t6_restore_done");
        repeat (10) @(posedge ref_clk_i);
        aon2 = aon_reg_o[95:64];
        got_new = (aon2 == 32'hA5A5A5A5);
        chk("t6_aon_old_or_new", (got_new || aon2 == 32'h12000078), 1'b1);
        chk("t6_pulse_consistent", pulse_cnt[2] - p0[2], got_new ? 1 : 0);
        m_aon[2] = got_new ? 32'hA5A5A5A5 : 32'h12000078;
        restore_model();
        @(negedge HCLK);
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) p0[i] = pulse_cnt[i];
        apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd, er, w);
        chk("t6_post_err", er, 1'b0);
        chk("t6_post_pulse3", pulse_cnt[3] - p0[3], 1);
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, rd, er, w);
        chk("t6_post_readback", rd, 32'hDEADBEEF);
        chk("t6_post_aon3", aon_reg_o[127:96], 32'hDEADBEEF);

        repeat (5) @(negedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
